cordic_iq_accumulator: RTL and testbench
========================================

// Module: cordic_iq_accumulator
// PURPOSE
//  Downstream consumer of cordic_sin_cos: synchronous (lock-in) I/Q detector for the sensor channel.
//  Delays each signed input sample by SAMPLE_DELAY CE-cycles to align it with SIN/COS.
//  Multiplies the aligned sample by COS (I) and SIN (Q), sums PERIOD products, then emits I/Q with a 1-cycle valid.
// PARAMETERS
//  DATA_BITS     16  width of signed SIN/COS inputs
//  SAMPLE_BITS   16  width of signed SAMPLE input
//  PERIOD_BITS   12  width of PERIOD; PERIOD=0 means 2**PERIOD_BITS samples
//  ACC_BITS      48  accumulator/output width; elaboration error if < DATA_BITS+SAMPLE_BITS+PERIOD_BITS
//  SAMPLE_DELAY  12  CE-cycles SAMPLE is delayed (= CORDIC latency); 0 = no delay line
// PORTS
//  CLK        in   1            clock, all logic on rising edge
//  RESET_N    in   1            synchronous reset, active-low
//  CE         in   1            clock enable; one sample per CE=1 cycle
//  SAMPLE     in   SAMPLE_BITS  signed sample, same cycle as the PHASE fed to the CORDIC
//  SIN        in   DATA_BITS    signed CORDIC sine output
//  COS        in   DATA_BITS    signed CORDIC cosine output
//  START      in   1            request new integration; sampled only when CE=1
//  PERIOD     in   PERIOD_BITS  number of samples to integrate; latched on accepted START
//  BUSY       out  1            high from accepted START until OUT_VALID
//  OUT_VALID  out  1            1-cycle pulse: I_OUT/Q_OUT updated
//  I_OUT      out  ACC_BITS     signed sum(SAMPLE_aligned*COS)
//  Q_OUT      out  ACC_BITS     signed sum(SAMPLE_aligned*SIN)
// BEHAVIOUR
//  Reset (RESET_N=0 at edge): BUSY=0, OUT_VALID=0, I_OUT=Q_OUT=0; state IDLE.
//   Delay line, pipeline valids, counter and accumulators cleared.
//  Reset mid-integration aborts; no OUT_VALID is produced.
//  Delay line: shift register of SAMPLE_DELAY stages, advances only when CE=1, in every state.
//   SAMPLE_aligned = SAMPLE from SAMPLE_DELAY CE-cycles earlier; holds when CE=0.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//   IDLE: START&CE -> latch PERIOD, clear count and accumulators, BUSY=1, go ACCUM.
//    The START cycle itself contributes no sample.
//   ACCUM: each CE=1 cycle captures (SAMPLE_aligned, SIN, COS) into stage 1 and count++.
//    CE=0 captures nothing.
//    After the PERIOD-th capture -> DRAIN.
//   DRAIN: pipeline empties without CE: stage 2 = products (full width DATA_BITS+SAMPLE_BITS, signed).
//    Stage 3 = accumulate (sign-extended to ACC_BITS).
//    Edge 3 after the last capture: I_OUT/Q_OUT <= accumulators, OUT_VALID=1 for exactly one cycle, BUSY=0, go IDLE.
//  Latency: last capture edge E -> OUT_VALID high in the cycle after edge E+3.
//   With CE=1 continuously: START at edge S, OUT_VALID after edge S+PERIOD+3.
//  Stage valid bits travel with data; CE only gates captures, never the stage 2/3 pipeline.
//  START while BUSY or with CE=0: ignored; PERIOD changes while BUSY have no effect.
//  START in the OUT_VALID cycle (state IDLE): accepted normally.
//  Arithmetic: two's complement, no saturation.
//   ACC_BITS sizing rule guarantees no overflow, including -2**(S-1) * -2**(D-1) products.
//  I_OUT/Q_OUT hold between OUT_VALID pulses.
// TESTING
//  1 Reset: RESET_N=0 for 3 cycles mid-ACCUM -> BUSY=0, I_OUT=Q_OUT=0, no OUT_VALID.
//    Next START runs normally.
//  2 SAMPLE_DELAY=0, CE=1, SAMPLE=1000, COS=16384, SIN=0, PERIOD=4, START at edge S.
//    Required: I_OUT=65536000, Q_OUT=0, OUT_VALID one cycle after edge S+7.
//  3 Extremes: SAMPLE=-32768, SIN=-32768, COS=32767, PERIOD=0 (4096 samples).
//    Required: Q_OUT=2**42, I_OUT=-4096*32768*32767.
//  4 CE alternating 1/0, PERIOD=3, SAMPLE=1, COS=1 -> I_OUT=3 (only CE=1 cycles count).
//    Required: BUSY stays high throughout; START pulsed while BUSY is ignored.
//  5 Alignment: default SAMPLE_DELAY=12, SAMPLE impulse 100 at CE-cycle k, else 0; COS ramps +1 per CE-cycle.
//    Required: I_OUT=100*COS at CE-cycle k+12.
//  6 Back-to-back: START in the OUT_VALID cycle.
//    Required: second integration starts immediately; results independent of the first.

Source files
------------

// File: rtl/cordic_iq_accumulator.sv
// cordic_iq_accumulator: lock-in I/Q detector that sits behind cordic_sin_cos.
// Each sample is delayed to line up with the CORDIC outputs, multiplied by
// COS (I) and SIN (Q), and summed over PERIOD samples. The totals are then
// presented with a one-cycle OUT_VALID strobe.
module cordic_iq_accumulator #(
  parameter int DATA_BITS    = 16,
  parameter int SAMPLE_BITS  = 16,
  parameter int PERIOD_BITS  = 12,
  parameter int ACC_BITS     = 48,
  parameter int SAMPLE_DELAY = 12
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CE,
  input  logic [SAMPLE_BITS-1:0] SAMPLE,
  input  logic [DATA_BITS-1:0]   SIN,
  input  logic [DATA_BITS-1:0]   COS,
  input  logic                   START,
  input  logic [PERIOD_BITS-1:0] PERIOD,
  output logic                   BUSY,
  output logic                   OUT_VALID,
  output logic [ACC_BITS-1:0]    I_OUT,
  output logic [ACC_BITS-1:0]    Q_OUT
);

  localparam int PROD_BITS = DATA_BITS + SAMPLE_BITS;
  localparam int CNT_BITS  = PERIOD_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // The accumulator must hold 2**PERIOD_BITS worst-case products without wrapping.
  generate
    if (ACC_BITS < DATA_BITS + SAMPLE_BITS + PERIOD_BITS) begin : g_acc_width_check
      $error("cordic_iq_accumulator: ACC_BITS must be >= DATA_BITS+SAMPLE_BITS+PERIOD_BITS");
    end
  endgenerate

  logic [SAMPLE_BITS-1:0] sample_aligned;

  generate
    if (SAMPLE_DELAY == 0) begin : g_no_delay
      assign sample_aligned = SAMPLE;
    end else begin : g_delay
      logic [SAMPLE_BITS-1:0] dly_q [SAMPLE_DELAY];
      logic [SAMPLE_BITS-1:0] dly_d [SAMPLE_DELAY];

      // Shift register that advances once per CE cycle, independent of the FSM.
      always_comb begin
        for (int i = 0; i < SAMPLE_DELAY; i++) begin
          dly_d[i] = dly_q[i];
        end
        if (CE) begin
          dly_d[0] = SAMPLE;
          for (int i = 1; i < SAMPLE_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
      end

      // Delay-line registers, cleared so stale samples never leak after reset.
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          for (int i = 0; i < SAMPLE_DELAY; i++) begin
            dly_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < SAMPLE_DELAY; i++) begin
            dly_q[i] <= dly_d[i];
          end
        end
      end

      assign sample_aligned = dly_q[SAMPLE_DELAY-1];
    end
  endgenerate

  logic [1:0]                  state_q, state_d;
  logic [PERIOD_BITS-1:0]      period_q, period_d;
  logic [CNT_BITS-1:0]         count_q, count_d;
  logic [CNT_BITS-1:0]         count_next;
  logic [CNT_BITS-1:0]         period_target;
  logic                        capture;

  logic                        s1_valid_q, s1_valid_d;
  logic [SAMPLE_BITS-1:0]      s1_sample_q, s1_sample_d;
  logic [DATA_BITS-1:0]        s1_sin_q, s1_sin_d;
  logic [DATA_BITS-1:0]        s1_cos_q, s1_cos_d;

  logic                        s2_valid_q, s2_valid_d;
  logic signed [PROD_BITS-1:0] prod_cos_q, prod_cos_d;
  logic signed [PROD_BITS-1:0] prod_sin_q, prod_sin_d;

  logic signed [ACC_BITS-1:0]  acc_cos_q, acc_cos_d;
  logic signed [ACC_BITS-1:0]  acc_sin_q, acc_sin_d;

  logic                        out_valid_q, out_valid_d;
  logic [ACC_BITS-1:0]         i_out_q, i_out_d;
  logic [ACC_BITS-1:0]         q_out_q, q_out_d;

  // PERIOD=0 encodes 2**PERIOD_BITS, which is exactly the extra top bit set.
  assign period_target = {(period_q == '0), period_q};
  assign count_next    = count_q + CNT_BITS'(1);
  assign capture       = (state_q == ACCUM) && CE;

  // Next-state logic for the FSM, the three-stage datapath and the output registers.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;

    s1_valid_d  = capture;
    s1_sample_d = s1_sample_q;
    s1_sin_d    = s1_sin_q;
    s1_cos_d    = s1_cos_q;
    if (capture) begin
      s1_sample_d = sample_aligned;
      s1_sin_d    = SIN;
      s1_cos_d    = COS;
    end

    s2_valid_d = s1_valid_q;
    prod_cos_d = prod_cos_q;
    prod_sin_d = prod_sin_q;
    if (s1_valid_q) begin
      prod_cos_d = PROD_BITS'($signed(s1_sample_q)) * PROD_BITS'($signed(s1_cos_q));
      prod_sin_d = PROD_BITS'($signed(s1_sample_q)) * PROD_BITS'($signed(s1_sin_q));
    end

    acc_cos_d = acc_cos_q;
    acc_sin_d = acc_sin_q;
    if (s2_valid_q) begin
      acc_cos_d = acc_cos_q + ACC_BITS'(prod_cos_q);
      acc_sin_d = acc_sin_q + ACC_BITS'(prod_sin_q);
    end

    case (state_q)
      IDLE: begin
        if (START && CE) begin
          period_d  = PERIOD;
          count_d   = '0;
          acc_cos_d = '0;
          acc_sin_d = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (CE) begin
          count_d = count_next;
          if (count_next == period_target) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          out_valid_d = 1'b1;
          i_out_d     = acc_cos_q;
          q_out_d     = acc_sin_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers, with a synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      period_q    <= '0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_sin_q    <= '0;
      s1_cos_q    <= '0;
      s2_valid_q  <= 1'b0;
      prod_cos_q  <= '0;
      prod_sin_q  <= '0;
      acc_cos_q   <= '0;
      acc_sin_q   <= '0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_sin_q    <= s1_sin_d;
      s1_cos_q    <= s1_cos_d;
      s2_valid_q  <= s2_valid_d;
      prod_cos_q  <= prod_cos_d;
      prod_sin_q  <= prod_sin_d;
      acc_cos_q   <= acc_cos_d;
      acc_sin_q   <= acc_sin_d;
      out_valid_q <= out_valid_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign OUT_VALID = out_valid_q;
  assign I_OUT     = i_out_q;
  assign Q_OUT     = q_out_q;

endmodule

// File: tb/tb_cordic_iq_accumulator.sv
// tb_cordic_iq_accumulator: drives two instances (no delay line and the
// default 12-stage delay line) with shared stimulus and compares both against
// a sample-history model of the lock-in sums.
module tb_cordic_iq_accumulator;

  logic clk = 1'b0;
  logic resetN;
  logic ce;
  logic start;
  logic [15:0] sample;
  logic [15:0] sinV;
  logic [15:0] cosV;
  logic [11:0] period;

  logic busy0, valid0, busy12, valid12;
  logic signed [47:0] i0, q0, i12, q12;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Every SAMPLE seen on a CE=1 cycle since the last reset, oldest first.
  int hist[$];

  int mode;
  int fixSample, fixSin, fixCos;
  int rampIdx, impulseIdx;

  longint lastI0 = 0, lastQ0 = 0, lastI12 = 0, lastQ12 = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  cordic_iq_accumulator #(.SAMPLE_DELAY(0)) dut0 (
    .CLK(clk), .RESET_N(resetN), .CE(ce), .SAMPLE(sample), .SIN(sinV), .COS(cosV),
    .START(start), .PERIOD(period), .BUSY(busy0), .OUT_VALID(valid0),
    .I_OUT(i0), .Q_OUT(q0)
  );

  cordic_iq_accumulator dut12 (
    .CLK(clk), .RESET_N(resetN), .CE(ce), .SAMPLE(sample), .SIN(sinV), .COS(cosV),
    .START(start), .PERIOD(period), .BUSY(busy12), .OUT_VALID(valid12),
    .I_OUT(i12), .Q_OUT(q12)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: record what the delay line sees, then settle past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    if (!resetN) begin
      hist.delete();
    end else if (ce) begin
      hist.push_back(int'($signed(sample)));
      rampIdx++;
    end
    #1;
  endtask

  // Sample that lines up with SIN/COS on the current cycle for a d-stage delay.
  function automatic longint alignedSample(input int d);
    if (d == 0) return longint'($signed(sample));
    if (hist.size() < d) return 0;
    return longint'(hist[hist.size() - d]);
  endfunction

  task automatic setData();
    case (mode)
      0: begin
        sample = 16'(fixSample);
        sinV   = 16'(fixSin);
        cosV   = 16'(fixCos);
      end
      1: begin
        sample = 16'($urandom);
        sinV   = 16'($urandom);
        cosV   = 16'($urandom);
      end
      default: begin
        sample = (rampIdx == impulseIdx) ? 16'd100 : 16'd0;
        sinV   = 16'd0;
        cosV   = 16'(5 + rampIdx);
      end
    endcase
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      ce = 1'($urandom_range(1));
      setData();
      applyStimulus();
      checkOutput("idle valid0", valid0, 0);
      checkOutput("idle busy0", busy0, 0);
      checkOutput("idle hold I0", i0, lastI0);
      checkOutput("idle hold Q12", q12, lastQ12);
    end
  endtask

  // ceMode: 0 = CE always high, 1 = alternating starting high, 2 = random.
  // noise: pulse START and scramble PERIOD while the integration is busy.
  task automatic runIntegration(input int periodVal, input int ceMode, input bit noise);
    longint eI0, eQ0, eI12, eQ12, a0, a12, c, s;
    int n, got, cyc;
    eI0 = 0; eQ0 = 0; eI12 = 0; eQ12 = 0;
    n   = (periodVal == 0) ? 4096 : periodVal;
    got = 0;
    cyc = 0;

    start  = 1'b1;
    ce     = 1'b1;
    period = 12'(periodVal);
    setData();
    applyStimulus();
    start = 1'b0;
    checkOutput("busy0 after start", busy0, 1);
    checkOutput("busy12 after start", busy12, 1);
    checkOutput("valid0 single pulse", valid0, 0);
    checkOutput("I0 held", i0, lastI0);
    checkOutput("Q12 held", q12, lastQ12);

    while (got < n) begin
      case (ceMode)
        0:       ce = 1'b1;
        1:       ce = (cyc % 2 == 0);
        default: ce = ($urandom_range(3) != 0);
      endcase
      if (noise) begin
        start  = 1'($urandom_range(1));
        period = 12'($urandom);
      end
      setData();
      if (ce) begin
        a0  = alignedSample(0);
        a12 = alignedSample(12);
        c   = longint'($signed(cosV));
        s   = longint'($signed(sinV));
        eI0  += a0 * c;
        eQ0  += a0 * s;
        eI12 += a12 * c;
        eQ12 += a12 * s;
        got++;
      end
      applyStimulus();
      cyc++;
      checkOutput("busy0 during", busy0, 1);
      checkOutput("busy12 during", busy12, 1);
      checkOutput("valid0 early", valid0, 0);
    end

    for (int k = 1; k <= 3; k++) begin
      ce    = (ceMode == 0) ? 1'b1 : 1'($urandom_range(1));
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      setData();
      applyStimulus();
      if (k < 3) begin
        checkOutput("valid0 drain", valid0, 0);
        checkOutput("valid12 drain", valid12, 0);
        checkOutput("busy0 drain", busy0, 1);
      end else begin
        checkOutput("valid0 at last+3", valid0, 1);
        checkOutput("valid12 at last+3", valid12, 1);
        checkOutput("busy0 at done", busy0, 0);
        checkOutput("busy12 at done", busy12, 0);
        checkOutput("I0 result", i0, eI0);
        checkOutput("Q0 result", q0, eQ0);
        checkOutput("I12 result", i12, eI12);
        checkOutput("Q12 result", q12, eQ12);
      end
    end
    start = 1'b0;
    lastI0 = eI0; lastQ0 = eQ0; lastI12 = eI12; lastQ12 = eQ12;
  endtask

  task automatic resetFor(input int n);
    resetN = 1'b0;
    start  = 1'b0;
    for (int k = 0; k < n; k++) applyStimulus();
    resetN = 1'b1;
    lastI0 = 0; lastQ0 = 0; lastI12 = 0; lastQ12 = 0;
  endtask

  // Directed sequence followed by randomized integrations.
  initial begin
    resetN = 1'b0; ce = 1'b0; start = 1'b0; period = '0;
    sample = '0; sinV = '0; cosV = '0;
    mode = 1; fixSample = 0; fixSin = 0; fixCos = 0; rampIdx = 0; impulseIdx = 0;

    resetFor(3);
    checkOutput("reset busy0", busy0, 0);
    checkOutput("reset valid0", valid0, 0);
    checkOutput("reset I0", i0, 0);
    checkOutput("reset Q0", q0, 0);
    checkOutput("reset I12", i12, 0);

    // Constant sample times half-scale cosine over four samples.
    mode = 0; fixSample = 1000; fixCos = 16384; fixSin = 0;
    runIntegration(4, 0, 1'b0);
    checkOutput("basic I0 const", i0, 64'sd65536000);
    checkOutput("basic Q0 const", q0, 0);

    // Back-to-back starts, each in the previous OUT_VALID cycle.
    mode = 1;
    runIntegration(5, 0, 1'b0);
    runIntegration(3, 2, 1'b1);

    // Alternating CE with START/PERIOD noise while busy.
    mode = 0; fixSample = 1; fixCos = 1; fixSin = 0;
    idleCycles(2);
    runIntegration(3, 1, 1'b1);
    checkOutput("ce gated I0 const", i0, 3);

    // Reset in the middle of an integration.
    mode = 1;
    start = 1'b1; ce = 1'b1; period = 12'd10; setData(); applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin setData(); applyStimulus(); end
    resetFor(3);
    checkOutput("abort busy0", busy0, 0);
    checkOutput("abort busy12", busy12, 0);
    checkOutput("abort I0", i0, 0);
    checkOutput("abort Q0", q0, 0);
    checkOutput("abort I12", i12, 0);
    checkOutput("abort valid0", valid0, 0);
    idleCycles(6);
    runIntegration(6, 2, 1'b0);

    // Delay-line alignment: impulse at CE-cycle 2, cosine ramp 5+idx.
    resetFor(2);
    mode = 2; rampIdx = 0; impulseIdx = 2;
    runIntegration(20, 0, 1'b0);
    checkOutput("align I12 const", i12, 100 * (5 + 2 + 12));
    checkOutput("align I0 const", i0, 100 * (5 + 2));

    // Full-scale operands over the maximum 4096-sample period.
    mode = 0; fixSample = -32768; fixSin = -32768; fixCos = 32767;
    runIntegration(0, 0, 1'b0);
    checkOutput("extreme Q0 const", q0, 64'sd1 <<< 42);
    checkOutput("extreme I0 const", i0, -64'sd4096 * 64'sd32768 * 64'sd32767);

    mode = 1;
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(1) == 1) idleCycles($urandom_range(1, 3));
      runIntegration($urandom_range(1, 40), 2, 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
